// File: rtl/spi_note_pkg.sv
// Shared constants and state encoding for the SPI note transmitter.
package spi_note_pkg;

  localparam int PKT_BITS  = 24;
  localparam int TUNE_BITS = 16;
  localparam int VOL_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Loadable down-counter: after a load of N, o_expire is high during the last of the
// N following cycles, so the caller can reload on that same edge without a dead cycle.
module spi_bit_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  // count down from the loaded value and park at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = (r_cnt == ONE);

endmodule

// File: rtl/spi_note_tx.sv
// SPI initiator: shifts {tuneWord, volume} out MSB-first as one 24-bit frame under an
// active-high chipSelect, then holds chipSelect low for a gap before taking the next note.
module spi_note_tx
  import spi_note_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 noteValid,
  input  logic [TUNE_BITS-1:0] tuneWord,
  input  logic [VOL_BITS-1:0]  volume,
  output logic                 noteReady,
  output logic                 busy,
  output logic                 chipSelect,
  output logic                 sck,
  output logic                 sdo
);
  localparam int               CNT_W      = $clog2(max_int(CLK_DIV, CS_GAP) + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_GAP);
  localparam logic [4:0]       FRAME_BITS = 5'(PKT_BITS);

  tx_state_t           r_state, w_next_state;
  logic [PKT_BITS-1:0] r_shift, w_next_shift;
  logic [4:0]          r_bit_cnt, w_next_bit_cnt, w_bit_inc;
  logic                w_load, w_expire;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_next_cs, w_next_sck, w_next_sdo, w_next_ready;
  logic                r_cs, r_sck, r_sdo, r_ready, r_busy;

  assign w_bit_inc = r_bit_cnt + 5'd1;

  spi_bit_timer #(
    .W(CNT_W)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  // next-state, shift register, bit counter and timer reload
  always_comb begin
    w_next_state   = r_state;
    w_next_shift   = r_shift;
    w_next_bit_cnt = r_bit_cnt;
    w_load         = 1'b0;
    w_load_val     = HALF_LOAD;
    case (r_state)
      IDLE: begin
        if (noteValid) begin
          w_next_state   = SETUP;
          w_next_shift   = {tuneWord, volume};
          w_next_bit_cnt = 5'd0;
          w_load         = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SETUP, LOW: begin
        if (w_expire) begin
          w_next_state = HIGH;
          w_load       = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      HIGH: begin
        if (w_expire) begin
          w_next_bit_cnt = w_bit_inc;
          w_load         = 1'b1;
          // the next bit is presented as sck falls, giving a full half-period of setup
          if (w_bit_inc < FRAME_BITS) begin
            w_next_state = LOW;
            w_next_shift = {r_shift[PKT_BITS-2:0], 1'b0};
          end else begin
            w_next_state = HOLD;
          end
        end else begin
          w_next_state = HIGH;
        end
      end
      HOLD: begin
        if (w_expire) begin
          w_next_state = GAP;
          w_load       = 1'b1;
          w_load_val   = GAP_LOAD;
        end else begin
          w_next_state = HOLD;
        end
      end
      GAP: begin
        if (w_expire) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GAP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // pin values for the upcoming state, so every output leaves a flop
  always_comb begin
    w_next_cs    = 1'b0;
    w_next_sck   = 1'b0;
    w_next_ready = 1'b0;
    case (w_next_state)
      IDLE:             w_next_ready = 1'b1;
      SETUP, LOW, HOLD: w_next_cs    = 1'b1;
      HIGH: begin
        w_next_cs  = 1'b1;
        w_next_sck = 1'b1;
      end
      GAP:              w_next_cs    = 1'b0;
      default:          w_next_ready = 1'b0;
    endcase
    w_next_sdo = w_next_cs & w_next_shift[PKT_BITS-1];
  end

  // state, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= 5'd0;
      r_cs      <= 1'b0;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_next_shift;
      r_bit_cnt <= w_next_bit_cnt;
      r_cs      <= w_next_cs;
      r_sck     <= w_next_sck;
      r_sdo     <= w_next_sdo;
      r_ready   <= w_next_ready;
      r_busy    <= ~w_next_ready;
    end
  end

  assign noteReady  = r_ready;
  assign busy       = r_busy;
  assign chipSelect = r_cs;
  assign sck        = r_sck;
  assign sdo        = r_sdo;

endmodule

// File: tb/tb_spi_note_tx.sv
// Bench for spi_note_tx: two instances (slow and fastest timing), a behavioural SPI
// receiver per instance, and frame/timing expectations computed from the link rules.
module tb_spi_note_tx;
  localparam int A_DIV = 2;
  localparam int A_GAP = 8;
  localparam int B_DIV = 1;
  localparam int B_GAP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [15:0] a_tune = 16'h0, b_tune = 16'h0;
  logic [7:0] a_vol = 8'h0, b_vol = 8'h0;
  logic a_ready, a_busy, a_cs, a_sck, a_sdo;
  logic b_ready, b_busy, b_cs, b_sck, b_sdo;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  spi_note_tx #(.CLK_DIV(A_DIV), .CS_GAP(A_GAP)) dut_a (
    .clk(clk), .reset(reset), .noteValid(a_valid), .tuneWord(a_tune), .volume(a_vol),
    .noteReady(a_ready), .busy(a_busy), .chipSelect(a_cs), .sck(a_sck), .sdo(a_sdo));

  spi_note_tx #(.CLK_DIV(B_DIV), .CS_GAP(B_GAP)) dut_b (
    .clk(clk), .reset(reset), .noteValid(b_valid), .tuneWord(b_tune), .volume(b_vol),
    .noteReady(b_ready), .busy(b_busy), .chipSelect(b_cs), .sck(b_sck), .sdo(b_sdo));

  always @(posedge clk) cyc <= cyc + 1;

  // pin-level monitors, sampled on the falling clk edge
  logic a_pcs = 1'b0, a_psck = 1'b0, a_psdo = 1'b0, a_prdy = 1'b1;
  logic b_pcs = 1'b0, b_psck = 1'b0, b_psdo = 1'b0, b_prdy = 1'b1;
  int a_rise_q[$], a_fall_q[$], a_rdy_q[$], a_sckn_q[$];
  int b_rise_q[$], b_fall_q[$], b_rdy_q[$], b_sckn_q[$];
  int a_sckn = 0, a_viol = 0, b_sckn = 0, b_viol = 0, b_last_rise = 0, b_perbad = 0;

  always @(negedge clk) begin
    if (a_cs && !a_pcs) begin a_rise_q.push_back(cyc); a_sckn = 0; end
    if (!a_cs && a_pcs) begin a_fall_q.push_back(cyc); a_sckn_q.push_back(a_sckn); end
    if (a_sck && !a_psck && a_cs) a_sckn++;
    if (a_sdo != a_psdo && a_sck) a_viol++;
    if (a_ready && !a_prdy) a_rdy_q.push_back(cyc);
    a_pcs = a_cs; a_psck = a_sck; a_psdo = a_sdo; a_prdy = a_ready;
    if (b_cs && !b_pcs) begin b_rise_q.push_back(cyc); b_sckn = 0; end
    if (!b_cs && b_pcs) begin b_fall_q.push_back(cyc); b_sckn_q.push_back(b_sckn); end
    if (b_sck && !b_psck && b_cs) begin
      if (b_sckn > 0 && (cyc - b_last_rise) != 2 * B_DIV) b_perbad++;
      b_last_rise = cyc;
      b_sckn++;
    end
    if (b_sdo != b_psdo && b_sck) b_viol++;
    if (b_ready && !b_prdy) b_rdy_q.push_back(cyc);
    b_pcs = b_cs; b_psck = b_sck; b_psdo = b_sdo; b_prdy = b_ready;
  end

  // receivers: sample on sck rise, keep a frame only if exactly 24 bits arrived
  logic [23:0] a_rx_sh = 24'h0, b_rx_sh = 24'h0;
  int a_rx_n = 0, b_rx_n = 0;
  logic [23:0] a_rx_q[$], b_rx_q[$];

  always @(posedge a_sck or negedge a_cs) begin
    if (!a_cs) begin
      if (a_rx_n == 24) a_rx_q.push_back(a_rx_sh);
      a_rx_n = 0;
    end else begin
      a_rx_sh = {a_rx_sh[22:0], a_sdo};
      a_rx_n++;
    end
  end

  always @(posedge b_sck or negedge b_cs) begin
    if (!b_cs) begin
      if (b_rx_n == 24) b_rx_q.push_back(b_rx_sh);
      b_rx_n = 0;
    end else begin
      b_rx_sh = {b_rx_sh[22:0], b_sdo};
      b_rx_n++;
    end
  end

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic clear_mon();
    a_rise_q.delete(); a_fall_q.delete(); a_rdy_q.delete(); a_sckn_q.delete(); a_rx_q.delete();
    b_rise_q.delete(); b_fall_q.delete(); b_rdy_q.delete(); b_sckn_q.delete(); b_rx_q.delete();
    a_viol = 0; b_viol = 0; b_perbad = 0;
  endtask

  task automatic offer(input bit sel, input logic [15:0] t, input logic [7:0] v, output int t_acc);
    int w = 0;
    @(negedge clk);
    if (!sel) begin a_valid = 1'b1; a_tune = t; a_vol = v; end
    else begin b_valid = 1'b1; b_tune = t; b_vol = v; end
    while (((!sel) ? a_ready : b_ready) !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    t_acc = cyc;
    if (w >= 1000) begin n_err++; $display("FAIL accept_timeout: sel=%0d never ready", sel); end
    @(negedge clk);
    if (!sel) begin a_valid = 1'b0; a_tune = 16'($urandom); a_vol = 8'($urandom); end
    else begin b_valid = 1'b0; b_tune = 16'($urandom); b_vol = 8'($urandom); end
  endtask

  task automatic wait_idle(input bit sel);
    int w = 0;
    while (((!sel) ? a_ready : b_ready) !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) begin n_err++; $display("FAIL idle_timeout: sel=%0d stuck busy", sel); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_cs, a_sck, a_sdo, a_ready, a_busy} !== 5'b00010) begin
      n_err++; $display("FAIL reset_a: got %b expected 00010", {a_cs, a_sck, a_sdo, a_ready, a_busy});
    end
    n_vec++;
    if ({b_cs, b_sck, b_sdo, b_ready, b_busy} !== 5'b00010) begin
      n_err++; $display("FAIL reset_b: got %b expected 00010", {b_cs, b_sck, b_sdo, b_ready, b_busy});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    int t;
    clear_mon();
    offer(1'b0, 16'hA5C3, 8'h7F, t);
    n_vec++;
    if ({a_ready, a_busy} !== 2'b01) begin
      n_err++; $display("FAIL busy_after_accept: got %b expected 01", {a_ready, a_busy});
    end
    wait_idle(1'b0);
    n_vec++;
    if (a_rx_q.size() != 1 || a_rx_q[0] !== 24'b1010_0101_1100_0011_0111_1111) begin
      n_err++; $display("FAIL directed_bits: got %0d frames first %h expected A5C37F", a_rx_q.size(), (a_rx_q.size() > 0) ? a_rx_q[0] : 24'h0);
    end
    n_vec++;
    if (q0(a_rise_q) != t + 1 || q0(a_fall_q) - q0(a_rise_q) != 98) begin
      n_err++; $display("FAIL directed_cs: rise %0d len %0d expected rise %0d len 98", q0(a_rise_q), q0(a_fall_q) - q0(a_rise_q), t + 1);
    end
    n_vec++;
    if (q0(a_rdy_q) != t + 107) begin
      n_err++; $display("FAIL directed_ready: got %0d expected %0d", q0(a_rdy_q), t + 107);
    end
    n_vec++;
    if (q0(a_sckn_q) != 24 || a_viol != 0) begin
      n_err++; $display("FAIL directed_sck: rises %0d sdo_viol %0d expected 24/0", q0(a_sckn_q), a_viol);
    end
  endtask

  task automatic test_random_frames();
    int t;
    logic [15:0] tw;
    logic [7:0] vv;
    for (int i = 0; i < 6; i++) begin
      tw = 16'($urandom);
      vv = 8'($urandom);
      clear_mon();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      offer(1'b0, tw, vv, t);
      wait_idle(1'b0);
      n_vec++;
      if (a_rx_q.size() != 1 || a_rx_q[0] !== {tw, vv}) begin
        n_err++; $display("FAIL rand_frame[%0d]: got %h expected %h", i, (a_rx_q.size() > 0) ? a_rx_q[0] : 24'h0, {tw, vv});
      end
      n_vec++;
      if (q0(a_fall_q) - q0(a_rise_q) != 49 * A_DIV || q0(a_rdy_q) != t + 1 + 49 * A_DIV + A_GAP) begin
        n_err++; $display("FAIL rand_timing[%0d]: cs_len %0d ready %0d expected %0d %0d", i, q0(a_fall_q) - q0(a_rise_q), q0(a_rdy_q), 49 * A_DIV, t + 1 + 49 * A_DIV + A_GAP);
      end
      n_vec++;
      if (q0(a_sckn_q) != 24 || a_viol != 0) begin
        n_err++; $display("FAIL rand_sck[%0d]: rises %0d sdo_viol %0d expected 24/0", i, q0(a_sckn_q), a_viol);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, w;
    clear_mon();
    @(negedge clk);
    a_valid = 1'b1; a_tune = 16'h1234; a_vol = 8'h10;
    w = 0;
    while (a_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    t1 = cyc;
    @(negedge clk);
    a_tune = 16'h4321; a_vol = 8'h20;
    w = 0;
    while (a_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    t2 = cyc;
    if (w >= 1000) begin n_err++; $display("FAIL b2b_timeout: second note not accepted"); end
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(1'b0);
    n_vec++;
    if (a_rx_q.size() != 2 || a_rx_q[0] !== 24'h123410 || a_rx_q[1] !== 24'h432120) begin
      n_err++; $display("FAIL b2b_frames: got %0d frames expected 123410 then 432120", a_rx_q.size());
    end
    n_vec++;
    if (a_rise_q.size() != 2 || a_fall_q.size() < 1 || a_rise_q[1] - a_fall_q[0] != A_GAP + 1) begin
      n_err++; $display("FAIL b2b_gap: rises %0d gap %0d expected %0d", a_rise_q.size(), (a_rise_q.size() > 1) ? a_rise_q[1] - q0(a_fall_q) : -1, A_GAP + 1);
    end
    n_vec++;
    if (t2 != t1 + 1 + 49 * A_DIV + A_GAP) begin
      n_err++; $display("FAIL b2b_accept: got %0d expected %0d", t2 - t1, 1 + 49 * A_DIV + A_GAP);
    end
  endtask

  task automatic test_busy_change();
    int t, r;
    logic [15:0] tw;
    logic [7:0] vv;
    tw = 16'($urandom);
    vv = 8'($urandom);
    clear_mon();
    offer(1'b0, tw, vv, t);
    r = t + 1 + 49 * A_DIV + A_GAP;
    while (cyc < r - 1) begin
      @(negedge clk);
      a_valid = 1'($urandom); a_tune = 16'($urandom); a_vol = 8'($urandom);
    end
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(1'b0);
    repeat (150) @(negedge clk);
    n_vec++;
    if (a_rx_q.size() != 1 || a_rx_q[0] !== {tw, vv}) begin
      n_err++; $display("FAIL busy_ignore_data: got %0d frames first %h expected 1 of %h", a_rx_q.size(), (a_rx_q.size() > 0) ? a_rx_q[0] : 24'h0, {tw, vv});
    end
    n_vec++;
    if (a_rise_q.size() != 1) begin
      n_err++; $display("FAIL busy_no_extra: got %0d frames expected 1", a_rise_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, w;
    logic [15:0] tw;
    logic [7:0] vv;
    clear_mon();
    offer(1'b0, 16'($urandom), 8'($urandom), t);
    w = 0;
    while (a_sckn < 10 && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) begin n_err++; $display("FAIL reset_mid_timeout: sck edges never reached 10"); end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({a_cs, a_sck, a_sdo, a_ready, a_busy} !== 5'b00010) begin
      n_err++; $display("FAIL reset_async: got %b expected 00010", {a_cs, a_sck, a_sdo, a_ready, a_busy});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_rx_q.size() != 0) begin
      n_err++; $display("FAIL reset_partial: got %0d frames expected 0", a_rx_q.size());
    end
    n_vec++;
    if (a_cs !== 1'b0 || a_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_no_resume: cs %b ready %b expected 0/1", a_cs, a_ready);
    end
    tw = 16'($urandom);
    vv = 8'($urandom);
    clear_mon();
    offer(1'b0, tw, vv, t);
    wait_idle(1'b0);
    n_vec++;
    if (a_rx_q.size() != 1 || a_rx_q[0] !== {tw, vv}) begin
      n_err++; $display("FAIL reset_fresh: got %h expected %h", (a_rx_q.size() > 0) ? a_rx_q[0] : 24'h0, {tw, vv});
    end
  endtask

  task automatic test_fast_b();
    int t;
    logic [15:0] tw;
    logic [7:0] vv;
    for (int i = 0; i < 3; i++) begin
      tw = (i == 0) ? 16'hFFFF : 16'($urandom);
      vv = (i == 0) ? 8'h00 : 8'($urandom);
      clear_mon();
      offer(1'b1, tw, vv, t);
      wait_idle(1'b1);
      n_vec++;
      if (b_rx_q.size() != 1 || b_rx_q[0] !== {tw, vv}) begin
        n_err++; $display("FAIL fast_frame[%0d]: got %h expected %h", i, (b_rx_q.size() > 0) ? b_rx_q[0] : 24'h0, {tw, vv});
      end
      n_vec++;
      if (q0(b_fall_q) - q0(b_rise_q) != 49 || q0(b_rdy_q) != t + 1 + 49 + B_GAP) begin
        n_err++; $display("FAIL fast_timing[%0d]: cs_len %0d ready %0d expected 49 %0d", i, q0(b_fall_q) - q0(b_rise_q), q0(b_rdy_q), t + 54);
      end
      n_vec++;
      if (q0(b_sckn_q) != 24 || b_perbad != 0 || b_viol != 0) begin
        n_err++; $display("FAIL fast_sck[%0d]: rises %0d bad_period %0d sdo_viol %0d expected 24/0/0", i, q0(b_sckn_q), b_perbad, b_viol);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random_frames();
    test_back_to_back();
    test_busy_change();
    test_reset_mid();
    test_fast_b();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
